// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment table for the 7-segment scan driver.
// Segment vectors are active-high, bit6 = a ... bit0 = g.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
  localparam logic [SEG_W-1:0] SEG_ALL = 7'h7F;

  // Glyphs 0..F; b and d are lower-case so they stay distinct from 8 and 0.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input nibble_t nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decoder (active-high segments).
// Ports:
//   nib_i    - hex nibble
//   seg_c_o  - segments a..g on bits 6..0, combinational
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  nibble_t          nib_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb seg_c_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with per-slot ghost blanking and
// tear-free value updates applied only at frame boundaries.
// Optional feature: define SEG7_LZ_SUPPRESS_EN to blank leading zero digits.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   value_i    - packed hex nibbles, nibble k drives digit k (k=0 rightmost)
//   load_i     - capture value_i into the pending register
//   blank_i    - per-digit force-blank, sampled live
//   upd_ack_o  - one-cycle pulse when a pending value reaches the display
//   seg_o      - segments a..g on bits 6..0 (polarity per SEG_ACTIVE_LOW)
//   an_o       - one-hot digit enable (polarity per AN_ACTIVE_LOW)
//   frame_o    - one-cycle pulse when the scan wraps to digit 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NIB_W*N_DIGITS-1:0] value_i,
  input  logic                      load_i,
  input  logic [N_DIGITS-1:0]       blank_i,
  output logic                      upd_ack_o,
  output logic [SEG_W-1:0]          seg_o,
  output logic [N_DIGITS-1:0]       an_o,
  output logic                      frame_o
);

  localparam int unsigned VAL_W = NIB_W * N_DIGITS;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [SEG_W-1:0]    SEG_RST  = SEG_ACTIVE_LOW ? SEG_ALL : SEG_OFF;
  localparam logic [N_DIGITS-1:0] AN_RST   = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VAL_W-1:0]    disp_q, disp_d;
  logic [VAL_W-1:0]    pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                ack_q, frame_q;
  logic [SEG_W-1:0]    seg_q;
  logic [N_DIGITS-1:0] an_q;

  logic                slot_end_c, wrap_c, apply_c;
  nibble_t             disp_nib [N_DIGITS];
  nibble_t             cur_nib_c;
  logic [SEG_W-1:0]    dec_seg_c, seg_act_c;
  logic [N_DIGITS-1:0] an_act_c;
  logic                dig_blank_c;

  assign slot_end_c = (div_q == DIV_LAST);
  assign wrap_c     = slot_end_c && (idx_q == IDX_LAST);
  // A load landing in the wrap cycle supersedes the older pending value,
  // so nothing is applied at this wrap.
  assign apply_c    = wrap_c && pend_v_q && !load_i;

  // Scan counters, pending and display registers.
  always_comb begin
    div_d    = slot_end_c ? '0 : div_q + DIV_W'(1);
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (slot_end_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (load_i) begin
      pend_d   = value_i;
      pend_v_d = 1'b1;
    end else if (apply_c) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
  end

  // Nibble view of the displayed value.
  always_comb begin
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      disp_nib[k] = disp_q[k*NIB_W +: NIB_W];
    end
  end

  assign cur_nib_c = disp_nib[idx_q];

  seg7_hex_decode u_dec (
    .nib_i   (cur_nib_c),
    .seg_c_o (dec_seg_c)
  );

`ifdef SEG7_LZ_SUPPRESS_EN
  // Digit k is a leading zero when it and every digit above it are zero; digit 0 never is.
  logic [N_DIGITS-1:0] lz_c;
  logic                hi_zero_c;
  always_comb begin
    lz_c      = '0;
    hi_zero_c = 1'b1;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      hi_zero_c = hi_zero_c & (disp_nib[k] == 4'h0);
      lz_c[k]   = hi_zero_c;
    end
  end
  assign dig_blank_c = blank_i[idx_q] | lz_c[idx_q];
`else
  assign dig_blank_c = blank_i[idx_q];
`endif

  // Active-high segment and anode values for the current (div, idx) state.
  always_comb begin
    seg_act_c = dig_blank_c ? SEG_OFF : dec_seg_c;
    an_act_c  = '0;
    if (32'(div_q) >= BLANK_CYC) begin
      an_act_c[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
      seg_q    <= SEG_RST;
      an_q     <= AN_RST;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ack_q    <= apply_c;
      frame_q  <= wrap_c;
      seg_q    <= SEG_ACTIVE_LOW ? ~seg_act_c : seg_act_c;
      an_q     <= AN_ACTIVE_LOW ? ~an_act_c : an_act_c;
    end
  end

  assign upd_ack_o = ack_q;
  assign frame_o   = frame_q;
  assign seg_o     = seg_q;
  assign an_o      = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
// Two instances share stimulus: one active-high, one with both polarities inverted.
// Define SEG7_LZ_SUPPRESS_EN for both RTL and bench to exercise leading-zero suppression.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = N * SD;

  logic        clk;
  logic        rst;
  logic [15:0] value_i;
  logic        load_i;
  logic [3:0]  blank_i;

  logic        ack0, frame0, ack1, frame1;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;

  seg7_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i), .blank_i(blank_i),
    .upd_ack_o(ack0), .seg_o(seg0), .an_o(an0), .frame_o(frame0)
  );

  seg7_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i), .blank_i(blank_i),
    .upd_ack_o(ack1), .seg_o(seg1), .an_o(an1), .frame_o(frame1)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;
    logic       ack;
    logic [7:0] tid;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int acks_seen = 0;
  int frames_seen = 0;
  logic [7:0] tid = 8'd0;

  logic [6:0] tbl [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference state: s counts scan states since reset release.
  int          s = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_pv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] t, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL test%0d %s got %h want %h", t, name, got, want);
    end
  endtask

  // One clock with reset asserted; outputs must sit at the off state.
  task automatic reset_step();
    exp_t e;
    rst     = 1'b1;
    load_i  = 1'b0;
    value_i = 16'h0;
    s       = 0;
    m_disp  = 16'h0;
    m_pend  = 16'h0;
    m_pv    = 1'b0;
    e       = '0;
    e.tid   = tid;
    @(posedge clk);
    q.push_back(e);
    #2;
  endtask

  // One scan clock; expected outputs come from the state in which inputs are held.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] bl);
    exp_t e;
    int   dv, ix;
    logic wrap, dark;
    rst     = 1'b0;
    load_i  = ld;
    value_i = v;
    blank_i = bl;
    dv   = s % SD;
    ix   = (s / SD) % N;
    wrap = ((s % FR) == FR - 1);
    dark = bl[ix];
`ifdef SEG7_LZ_SUPPRESS_EN
    if (ix != 0 && (m_disp >> (4 * ix)) == 16'h0) dark = 1'b1;
`endif
    e.an    = (dv >= BC) ? 4'(1 << ix) : 4'h0;
    e.seg   = dark ? 7'h00 : tbl[m_disp[4*ix +: 4]];
    e.frame = wrap;
    e.ack   = wrap && m_pv && !ld;
    e.tid   = tid;
    if (ld) begin
      m_pend = v;
      m_pv   = 1'b1;
    end else if (wrap && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    s++;
    @(posedge clk);
    q.push_back(e);
    #2;
  endtask

  task automatic run(input int n, input logic [3:0] bl);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, bl);
  endtask

  // Monitor: the DUT presents a new output set every clock.
  initial begin : monitor
    exp_t       e;
    logic [6:0] al_seg;
    logic [3:0] al_an;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e      = q.pop_front();
        al_seg = ~e.seg;
        al_an  = ~e.an;
        chk("seg",      e.tid, 32'(seg0),   32'(e.seg));
        chk("an",       e.tid, 32'(an0),    32'(e.an));
        chk("frame",    e.tid, 32'(frame0), 32'(e.frame));
        chk("ack",      e.tid, 32'(ack0),   32'(e.ack));
        chk("seg_al",   e.tid, 32'(seg1),   32'(al_seg));
        chk("an_al",    e.tid, 32'(an1),    32'(al_an));
        chk("frame_al", e.tid, 32'(frame1), 32'(e.frame));
        chk("ack_al",   e.tid, 32'(ack1),   32'(e.ack));
        if (ack0)   acks_seen++;
        if (frame0) frames_seen++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst     = 1'b1;
    load_i  = 1'b0;
    value_i = 16'h0;
    blank_i = 4'h0;
    @(posedge clk);
    #2;

    tid = 8'd0;
    repeat (3) reset_step();

    // Reset release, first slot blanking, first frame pulse.
    tid = 8'd1;
    run(16, 4'h0);

    // Single load shown from the next frame on.
    tid = 8'd2;
    step(1'b1, 16'h1A3F, 4'h0);
    run(15, 4'h0);
    run(16, 4'h0);

    // Overwrite before the wrap: last value wins, one ack.
    tid = 8'd3;
    step(1'b1, 16'h1111, 4'h0);
    step(1'b1, 16'h2222, 4'h0);
    run(14, 4'h0);
    run(16, 4'h0);

    // Load in the wrap cycle supersedes an older pending value.
    tid = 8'd4;
    step(1'b1, 16'h4567, 4'h0);
    run(14, 4'h0);
    step(1'b1, 16'hBEEF, 4'h0);
    run(16, 4'h0);
    run(16, 4'h0);

    // Force-blank of digit 2 while anodes keep scanning.
    tid = 8'd5;
    step(1'b1, 16'h8888, 4'b0100);
    run(15, 4'b0100);
    run(16, 4'b0100);

    // Leading zeros (suppressed only when the feature is built in).
    tid = 8'd6;
    step(1'b1, 16'h0050, 4'h0);
    run(15, 4'h0);
    run(16, 4'h0);
    step(1'b1, 16'h0000, 4'h0);
    run(15, 4'h0);
    run(16, 4'h0);

    // Reset mid-frame discards a pending value without an ack.
    tid = 8'd7;
    step(1'b1, 16'h1234, 4'h0);
    run(5, 4'h0);
    repeat (2) reset_step();
    run(33, 4'h0);

    tid = 8'd8;
    #5;
    chk("queue_drain", tid, 32'(q.size()), 32'd0);
    chk("ack_count",   tid, 32'(acks_seen),   32'd6);
    chk("frame_count", tid, 32'(frames_seen), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
